// File: rtl/blit_fill_pkg.sv
// Purpose : shared constants and types for the blit_fill rectangle-fill engine.
//           Holds the XR blit register numbers, the CTRL START bit position,
//           the VRAM word width and the engine state encoding.
package blit_fill_pkg;

  localparam int WORD_W = 16;

  localparam logic [2:0] XR_BLIT_DST    = 3'd0;
  localparam logic [2:0] XR_BLIT_STRIDE = 3'd1;
  localparam logic [2:0] XR_BLIT_WIDTH  = 3'd2;
  localparam logic [2:0] XR_BLIT_HEIGHT = 3'd3;
  localparam logic [2:0] XR_BLIT_DATA   = 3'd4;
  localparam logic [2:0] XR_BLIT_CTRL   = 3'd5;

  localparam int BLIT_START_BIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } blit_state_t;

endpackage

// File: rtl/blit_fill_if.sv
// Purpose : VRAM request port between the fill engine and vram_arb.
// Signals : vram_sel     request (held until vram_ack)
//           vram_ack     grant; the write completes in the acked cycle
//           vram_wr      write enable, mirrors vram_sel
//           vram_wr_mask nibble write mask
//           vram_addr    VRAM word address
//           vram_data    VRAM write data
// Modports: master = requester (blit_fill), slave = arbiter.
interface blit_fill_if;
  import blit_fill_pkg::*;

  logic              vram_sel;
  logic              vram_ack;
  logic              vram_wr;
  logic [3:0]        vram_wr_mask;
  logic [WORD_W-1:0] vram_addr;
  logic [WORD_W-1:0] vram_data;

  modport master (
    output vram_sel,
    output vram_wr,
    output vram_wr_mask,
    output vram_addr,
    output vram_data,
    input  vram_ack
  );

  modport slave (
    input  vram_sel,
    input  vram_wr,
    input  vram_wr_mask,
    input  vram_addr,
    input  vram_data,
    output vram_ack
  );

endinterface

// File: rtl/blit_fill_addr_gen.sv
// Purpose : working address generator for a W x H rectangle walk.
//           Latches DST/STRIDE/WIDTH/HEIGHT on load, then advances one word
//           per step; at the end of each line it jumps to line_start+STRIDE.
// Ports   : clk, reset_i  clock / synchronous active-high reset
//           load_i        capture parameters and restart at DST
//           step_i        current word accepted, advance
//           dst_i, stride_i, width_i, height_i  shadow parameters
//           addr_o        current word address (registered)
//           last_o        current word is the last of the rectangle
module blit_fill_addr_gen
  import blit_fill_pkg::*;
(
  input  logic              clk,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [WORD_W-1:0] dst_i,
  input  logic [WORD_W-1:0] stride_i,
  input  logic [WORD_W-1:0] width_i,
  input  logic [WORD_W-1:0] height_i,
  output logic [WORD_W-1:0] addr_o,
  output logic              last_o
);

  logic [WORD_W-1:0] col_q, col_d;
  logic [WORD_W-1:0] row_q, row_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] line_q, line_d;
  logic [WORD_W-1:0] wid_q, wid_d;
  logic [WORD_W-1:0] hgt_q, hgt_d;
  logic [WORD_W-1:0] str_q, str_d;
  logic              eol_s;

  // End of the current line; width is never 0 once loaded.
  assign eol_s  = (col_q == (wid_q - 16'd1));
  assign last_o = eol_s && (row_q == (hgt_q - 16'd1));
  assign addr_o = addr_q;

  // Next-state for counters; all address arithmetic wraps modulo 2^16.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    line_d = line_q;
    wid_d  = wid_q;
    hgt_d  = hgt_q;
    str_d  = str_q;
    if (load_i) begin
      col_d  = 16'd0;
      row_d  = 16'd0;
      addr_d = dst_i;
      line_d = dst_i;
      wid_d  = width_i;
      hgt_d  = height_i;
      str_d  = stride_i;
    end else if (step_i) begin
      if (eol_s) begin
        col_d  = 16'd0;
        row_d  = row_q + 16'd1;
        addr_d = line_q + str_q;
        line_d = line_q + str_q;
      end else begin
        col_d  = col_q + 16'd1;
        addr_d = addr_q + 16'd1;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      col_q  <= 16'd0;
      row_q  <= 16'd0;
      addr_q <= 16'd0;
      line_q <= 16'd0;
      wid_q  <= 16'd0;
      hgt_q  <= 16'd0;
      str_q  <= 16'd0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      line_q <= line_d;
      wid_q  <= wid_d;
      hgt_q  <= hgt_d;
      str_q  <= str_d;
    end
  end

endmodule

// File: rtl/blit_fill.sv
// Purpose : VRAM rectangle-fill engine. Writes one constant nibble-masked
//           word over a W x H rectangle with a programmable line stride,
//           programmed through the XR blit register range.
// Ports   : clk, reset_i      clock / synchronous active-high reset
//           xreg_wr_i         XR register write strobe
//           xreg_num_i        blit register number (0 DST .. 5 CTRL)
//           xreg_data_i       XR write data
//           xreg_data_o       combinational readback of selected register
//           vram (master)     request port to vram_arb
//           busy_o            fill in progress
//           intr_signal_o     one-cycle completion pulse on bit INTR_BIT
module blit_fill #(
  parameter int INTR_BIT = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        xreg_wr_i,
  input  logic [2:0]  xreg_num_i,
  input  logic [15:0] xreg_data_i,
  output logic [15:0] xreg_data_o,
  blit_fill_if.master vram,
  output logic        busy_o,
  output logic [3:0]  intr_signal_o
);
  import blit_fill_pkg::*;

  blit_state_t state_q, state_d;

  // Shadow (programmed) registers.
  logic [15:0] dst_q, dst_d;
  logic [15:0] stride_q, stride_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [15:0] data_q, data_d;
  logic [14:0] ctrl_q, ctrl_d;

  // Working copies used by the operation in flight.
  logic [15:0] data_wk_q, data_wk_d;
  logic [3:0]  mask_wk_q, mask_wk_d;

  logic        start_s;
  logic        dims_ok_s;
  logic        load_s;
  logic        step_s;
  logic        last_s;
  logic        busy_s;
  logic [15:0] addr_s;

  assign start_s   = xreg_wr_i && (xreg_num_i == XR_BLIT_CTRL) && xreg_data_i[BLIT_START_BIT];
  assign dims_ok_s = (width_q != 16'd0) && (height_q != 16'd0);
  assign busy_s    = (state_q == FILL);

  // Shadow register writes; CTRL low bits are stored even while busy.
  always_comb begin
    dst_d    = dst_q;
    stride_d = stride_q;
    width_d  = width_q;
    height_d = height_q;
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    if (xreg_wr_i) begin
      case (xreg_num_i)
        XR_BLIT_DST:    dst_d    = xreg_data_i;
        XR_BLIT_STRIDE: stride_d = xreg_data_i;
        XR_BLIT_WIDTH:  width_d  = xreg_data_i;
        XR_BLIT_HEIGHT: height_d = xreg_data_i;
        XR_BLIT_DATA:   data_d   = xreg_data_i;
        XR_BLIT_CTRL:   ctrl_d   = xreg_data_i[14:0];
        default:        dst_d    = dst_q;
      endcase
    end else begin
      dst_d = dst_q;
    end
  end

  // Next-state logic; START is only honoured from IDLE.
  always_comb begin
    state_d   = state_q;
    load_s    = 1'b0;
    step_s    = 1'b0;
    data_wk_d = data_wk_q;
    mask_wk_d = mask_wk_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          if (dims_ok_s) begin
            state_d   = FILL;
            load_s    = 1'b1;
            data_wk_d = data_q;
            mask_wk_d = xreg_data_i[3:0];
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        step_s = vram.vram_ack;
        if (vram.vram_ack && last_s) begin
          state_d = DONE;
        end else begin
          state_d = FILL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and working registers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= IDLE;
      dst_q     <= 16'd0;
      stride_q  <= 16'd0;
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      data_q    <= 16'd0;
      ctrl_q    <= 15'd0;
      data_wk_q <= 16'd0;
      mask_wk_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      stride_q  <= stride_d;
      width_q   <= width_d;
      height_q  <= height_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      data_wk_q <= data_wk_d;
      mask_wk_q <= mask_wk_d;
    end
  end

  blit_fill_addr_gen u_addr_gen (
    .clk      (clk),
    .reset_i  (reset_i),
    .load_i   (load_s),
    .step_i   (step_s),
    .dst_i    (dst_q),
    .stride_i (stride_q),
    .width_i  (width_q),
    .height_i (height_q),
    .addr_o   (addr_s),
    .last_o   (last_s)
  );

  // Register readback; CTRL[15] reports busy.
  always_comb begin
    case (xreg_num_i)
      XR_BLIT_DST:    xreg_data_o = dst_q;
      XR_BLIT_STRIDE: xreg_data_o = stride_q;
      XR_BLIT_WIDTH:  xreg_data_o = width_q;
      XR_BLIT_HEIGHT: xreg_data_o = height_q;
      XR_BLIT_DATA:   xreg_data_o = data_q;
      XR_BLIT_CTRL:   xreg_data_o = {busy_s, ctrl_q};
      default:        xreg_data_o = 16'h0000;
    endcase
  end

  assign vram.vram_sel     = busy_s;
  assign vram.vram_wr      = busy_s;
  assign vram.vram_addr    = addr_s;
  assign vram.vram_data    = data_wk_q;
  assign vram.vram_wr_mask = mask_wk_q;
  assign busy_o            = busy_s;
  assign intr_signal_o     = (state_q == DONE) ? (4'b0001 << INTR_BIT) : 4'b0000;

endmodule

// File: tb/tb_blit_fill.sv
module tb_blit_fill;

  logic        clk;
  logic        reset_i;
  logic        xreg_wr_i;
  logic [2:0]  xreg_num_i;
  logic [15:0] xreg_data_i;
  logic [15:0] xreg_data_o;
  logic        busy_o;
  logic [3:0]  intr_signal_o;

  int checks;
  int failures;

  blit_fill_if vif ();

  blit_fill #(.INTR_BIT(2)) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .xreg_wr_i     (xreg_wr_i),
    .xreg_num_i    (xreg_num_i),
    .xreg_data_i   (xreg_data_i),
    .xreg_data_o   (xreg_data_o),
    .vram          (vif.master),
    .busy_o        (busy_o),
    .intr_signal_o (intr_signal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  num;
    logic [15:0] wdata;
    logic [15:0] exp;
  } reg_vec_t;

  reg_vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic xwrite(input logic [2:0] num, input logic [15:0] data);
    xreg_wr_i   = 1'b1;
    xreg_num_i  = num;
    xreg_data_i = data;
    tick();
    xreg_wr_i   = 1'b0;
  endtask

  task automatic program_op(input logic [15:0] dst, input logic [15:0] stride,
                            input logic [15:0] w, input logic [15:0] h,
                            input logic [15:0] data, input logic [3:0] mask);
    xwrite(3'd0, dst);
    xwrite(3'd1, stride);
    xwrite(3'd2, w);
    xwrite(3'd3, h);
    xwrite(3'd4, data);
    xwrite(3'd5, {1'b1, 11'd0, mask});
  endtask

  // Runs one operation; ack on every period-th FILL cycle. With mid=1 a DST
  // rewrite and a second START are issued while the op is running.
  task automatic fill_check(input string name, input logic [15:0] dst, input logic [15:0] stride,
                            input int w, input int h, input logic [15:0] data,
                            input logic [3:0] mask, input int period, input int exp_busy,
                            input bit mid);
    logic [15:0] exp_q[$];
    int  idx;
    int  busy_cnt;
    int  intr_k;
    bit  ack;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back(16'(int'(dst) + r * int'(stride) + c));
    idx = 0; busy_cnt = 0; intr_k = -1;
    program_op(dst, stride, 16'(w), 16'(h), data, mask);
    for (int cyc = 0; cyc < 100 && intr_k < 0; cyc++) begin
      if (mid && cyc == 2) begin
        xreg_wr_i = 1'b1; xreg_num_i = 3'd0; xreg_data_i = 16'h2000;
      end
      if (mid && cyc == 3) begin
        xreg_wr_i = 1'b1; xreg_num_i = 3'd5; xreg_data_i = 16'h8005;
      end
      if (mid && cyc == 4) begin
        xreg_wr_i = 1'b0; xreg_num_i = 3'd5;
        #1;
        chk({name, "_ctrl_busy_rb"}, 32'(xreg_data_o), 32'h8005);
      end
      ack = ((cyc % period) == (period - 1));
      if (busy_o) busy_cnt++;
      if (vif.vram_sel) begin
        chk({name, "_wr"}, 32'(vif.vram_wr), 32'd1);
        if (idx < exp_q.size()) begin
          chk({name, "_addr"}, 32'(vif.vram_addr), 32'(exp_q[idx]));
          chk({name, "_data"}, 32'(vif.vram_data), 32'(data));
          chk({name, "_mask"}, 32'(vif.vram_wr_mask), 32'(mask));
        end else begin
          chk({name, "_extra_word"}, 32'(idx), 32'(exp_q.size() - 1));
        end
        if (ack) idx++;
      end
      if (intr_signal_o != 4'b0000) begin
        intr_k = cyc;
        chk({name, "_intr_val"}, 32'(intr_signal_o), 32'h4);
        chk({name, "_done_sel"}, 32'(vif.vram_sel), 32'd0);
        chk({name, "_done_busy"}, 32'(busy_o), 32'd0);
      end
      vif.vram_ack = ack && vif.vram_sel;
      tick();
    end
    vif.vram_ack = 1'b0;
    xreg_wr_i = 1'b0;
    chk({name, "_intr_cycle"}, 32'(intr_k), 32'(exp_busy));
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({name, "_word_count"}, 32'(idx), 32'(exp_q.size()));
    chk({name, "_intr_1cyc"}, 32'(intr_signal_o), 32'h0);
    chk({name, "_idle_sel"}, 32'(vif.vram_sel), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_i = 1'b1; xreg_wr_i = 1'b0; xreg_num_i = 3'd0; xreg_data_i = 16'h0000;
    vif.vram_ack = 1'b0;

    vecs[0] = '{3'd0, 16'h1234, 16'h1234};
    vecs[1] = '{3'd1, 16'h00A0, 16'h00A0};
    vecs[2] = '{3'd2, 16'h0003, 16'h0003};
    vecs[3] = '{3'd3, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{3'd4, 16'h5A5A, 16'h5A5A};
    vecs[5] = '{3'd5, 16'h7FF3, 16'h7FF3};
    vecs[6] = '{3'd6, 16'hBEEF, 16'h0000};
    vecs[7] = '{3'd7, 16'hCAFE, 16'h0000};

    tick(); tick();
    // Reset state
    chk("rst_sel", 32'(vif.vram_sel), 32'd0);
    chk("rst_wr", 32'(vif.vram_wr), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_intr", 32'(intr_signal_o), 32'd0);
    chk("rst_addr", 32'(vif.vram_addr), 32'd0);
    chk("rst_data", 32'(vif.vram_data), 32'd0);
    chk("rst_mask", 32'(vif.vram_wr_mask), 32'd0);
    reset_i = 1'b0;
    tick();

    // Register write/readback table
    for (int i = 0; i < 8; i++) begin
      xwrite(vecs[i].num, vecs[i].wdata);
      xreg_num_i = vecs[i].num;
      #1;
      chk($sformatf("regrb_%0d", i), 32'(xreg_data_o), 32'(vecs[i].exp));
      chk($sformatf("regrb_nostart_%0d", i), 32'(busy_o), 32'd0);
    end

    fill_check("t1_ack1", 16'h1000, 16'd8, 4, 2, 16'hABCD, 4'hF, 1, 8, 1'b0);
    fill_check("t2_ack3", 16'h1000, 16'd8, 4, 2, 16'hABCD, 4'hF, 3, 24, 1'b0);
    fill_check("t3_w0", 16'h3000, 16'd8, 0, 5, 16'h1111, 4'h3, 1, 0, 1'b0);
    fill_check("t4_wrap", 16'hFFFE, 16'h0010, 4, 1, 16'h00FF, 4'h9, 1, 4, 1'b0);
    fill_check("t5_restart", 16'h1000, 16'd8, 4, 2, 16'hABCD, 4'hF, 1, 8, 1'b1);
    xreg_num_i = 3'd0;
    #1;
    chk("t5_dst_rb", 32'(xreg_data_o), 32'h2000);
    xreg_num_i = 3'd5;
    #1;
    chk("t5_ctrl_rb", 32'(xreg_data_o), 32'h0005);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_new_op", 32'(vif.vram_sel), 32'd0);
    end

    // Reset in the middle of a fill, after 3 acks
    program_op(16'h1000, 16'd8, 16'd4, 16'd2, 16'hABCD, 4'hF);
    vif.vram_ack = 1'b1;
    tick(); tick(); tick();
    chk("t6_pre_sel", 32'(vif.vram_sel), 32'd1);
    chk("t6_pre_addr", 32'(vif.vram_addr), 32'h1003);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    vif.vram_ack = 1'b0;
    chk("t6_sel", 32'(vif.vram_sel), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_addr", 32'(vif.vram_addr), 32'd0);
    chk("t6_data", 32'(vif.vram_data), 32'd0);
    chk("t6_mask", 32'(vif.vram_wr_mask), 32'd0);
    chk("t6_intr", 32'(intr_signal_o), 32'd0);
    xreg_num_i = 3'd0;
    #1;
    chk("t6_dst_cleared", 32'(xreg_data_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_intr", 32'(intr_signal_o), 32'd0);
      chk("t6_stay_idle", 32'(vif.vram_sel), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
